// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// The wait counter is sized for the largest legal WAIT_CYCLES value.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

    typedef enum logic {
        CPU,
        DBG
    } requester_t;

    localparam int MAX_WAIT_CYCLES = 15;
    localparam int WAIT_CNT_W      = $clog2(MAX_WAIT_CYCLES + 1);

endpackage

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM between the CPU memory port
// and the debug/program loader, sequencing fixed-length active-low read/write strobes.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,

    output logic [ADDR_W-1:0] Mem_ADDR,
    output logic [DATA_W-1:0] Mem_Dout,
    output logic              Mem_Dout_en,
    input  logic [DATA_W-1:0] Mem_Din,
    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic              busy
);

    localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE  = WAIT_CNT_W'(1);

    arb_state_t              state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    requester_t              grant_q, grant_d;
    requester_t              last_grant_q, last_grant_d;
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]       mem_dout_q, mem_dout_d;
    logic                    mem_dout_en_q, mem_dout_en_d;
    logic                    mem_oe_q, mem_oe_d;
    logic                    mem_we_q, mem_we_d;
    logic [DATA_W-1:0]       cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]       dbg_rdata_q, dbg_rdata_d;
    logic                    cpu_ack_q, cpu_ack_d;
    logic                    dbg_ack_q, dbg_ack_d;
    logic                    busy_q, busy_d;

    requester_t              grant_sel;
    logic                    sel_we;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_wdata;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        we_d          = we_q;
        mem_addr_d    = mem_addr_q;
        mem_dout_d    = mem_dout_q;
        mem_dout_en_d = mem_dout_en_q;
        mem_oe_d      = mem_oe_q;
        mem_we_d      = mem_we_q;
        cpu_rdata_d   = cpu_rdata_q;
        dbg_rdata_d   = dbg_rdata_q;
        cpu_ack_d     = 1'b0;
        dbg_ack_d     = 1'b0;

        // On a tie the requester that did not win last time gets the SRAM.
        if (cpu_req && dbg_req) begin
            grant_sel = (last_grant_q == CPU) ? DBG : CPU;
        end else begin
            grant_sel = cpu_req ? CPU : DBG;
        end
        sel_we    = (grant_sel == CPU) ? cpu_we    : dbg_we;
        sel_addr  = (grant_sel == CPU) ? cpu_addr  : dbg_addr;
        sel_wdata = (grant_sel == CPU) ? cpu_wdata : dbg_wdata;

        case (state_q)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    grant_d       = grant_sel;
                    last_grant_d  = grant_sel;
                    we_d          = sel_we;
                    mem_addr_d    = sel_addr;
                    mem_dout_d    = sel_wdata;
                    mem_oe_d      = sel_we;
                    mem_we_d      = ~sel_we;
                    mem_dout_en_d = sel_we;
                    cnt_d         = CNT_LOAD;
                    state_d       = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    mem_oe_d      = 1'b1;
                    mem_we_d      = 1'b1;
                    mem_dout_en_d = 1'b0;
                    if (!we_q) begin
                        if (grant_q == CPU) begin
                            cpu_rdata_d = Mem_Din;
                        end else begin
                            dbg_rdata_d = Mem_Din;
                        end
                    end
                    cpu_ack_d = (grant_q == CPU);
                    dbg_ack_d = (grant_q == DBG);
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            grant_q       <= CPU;
            last_grant_q  <= DBG;
            we_q          <= 1'b0;
            mem_addr_q    <= '0;
            mem_dout_q    <= '0;
            mem_dout_en_q <= 1'b0;
            mem_oe_q      <= 1'b1;
            mem_we_q      <= 1'b1;
            cpu_rdata_q   <= '0;
            dbg_rdata_q   <= '0;
            cpu_ack_q     <= 1'b0;
            dbg_ack_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            we_q          <= we_d;
            mem_addr_q    <= mem_addr_d;
            mem_dout_q    <= mem_dout_d;
            mem_dout_en_q <= mem_dout_en_d;
            mem_oe_q      <= mem_oe_d;
            mem_we_q      <= mem_we_d;
            cpu_rdata_q   <= cpu_rdata_d;
            dbg_rdata_q   <= dbg_rdata_d;
            cpu_ack_q     <= cpu_ack_d;
            dbg_ack_q     <= dbg_ack_d;
            busy_q        <= busy_d;
        end
    end

    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_ack     = cpu_ack_q;
    assign dbg_rdata   = dbg_rdata_q;
    assign dbg_ack     = dbg_ack_q;
    assign Mem_ADDR    = mem_addr_q;
    assign Mem_Dout    = mem_dout_q;
    assign Mem_Dout_en = mem_dout_en_q;
    assign Mem_OE      = mem_oe_q;
    assign Mem_WE      = mem_we_q;
    assign busy        = busy_q;

    // Chip enable and byte lanes are permanently active.
    assign Mem_CE = 1'b0;
    assign Mem_UB = 1'b0;
    assign Mem_LB = 1'b0;

endmodule
